// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ITER_CNT = 32;
    localparam int unsigned CNT_W    = $clog2(ITER_CNT);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic              neg,
    output logic [DATA_W-1:0] dout
);

    assign dout = neg ? (~din + DATA_W'(1)) : din;

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative 32x32 MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU requests are ignored.
module hilo_muldiv
    import muldiv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_CNT - 1);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   count_q;
    logic [DATA_W-1:0]  p_hi_q, p_lo_q, opnd_q;
    logic               neg_lo_q, neg_hi_q, is_mul_q;

    logic               start_ok, start_mul, start_div;
    logic               is_signed, rs_neg, rt_neg;
    logic [DATA_W-1:0]  rs_mag, rt_mag;
    logic [DATA_W:0]    mul_sum;
    logic               hi_adj;
    logic [DATA_W-1:0]  hi_src, fix_hi, fix_lo;

    assign start_ok  = start_i & ~kill_i;
    assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign rs_neg    = is_signed & rs_i[DATA_W-1];
    assign rt_neg    = is_signed & rt_i[DATA_W-1];
    assign start_mul = start_ok && ((op_i == OP_MULT) || (op_i == OP_MULTU));

`ifdef MULDIV_DIV_EN
    logic                rt_zero;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;

    assign start_div = start_ok && ((op_i == OP_DIV) || (op_i == OP_DIVU));
    assign rt_zero   = (rt_i == '0);
    assign div_shift = {p_hi_q, p_lo_q[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
`else
    assign start_div = 1'b0;
`endif

    muldiv_signfix u_rs_mag (.din(rs_i), .neg(rs_neg), .dout(rs_mag));
    muldiv_signfix u_rt_mag (.din(rt_i), .neg(rt_neg), .dout(rt_mag));

    assign mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : '0);

    // 64-bit negate from two 32-bit negators: -(H:L) has upper word -(H+1) when L != 0.
    assign hi_adj = is_mul_q & neg_lo_q & (p_lo_q != '0);
    assign hi_src = p_hi_q + DATA_W'(hi_adj);

    muldiv_signfix u_fix_hi (.din(hi_src), .neg(is_mul_q ? neg_lo_q : neg_hi_q), .dout(fix_hi));
    muldiv_signfix u_fix_lo (.din(p_lo_q), .neg(neg_lo_q), .dout(fix_lo));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_mul) begin
                    state_n = ST_MUL;
                end else if (start_div) begin
                    state_n = ST_DIV;
                end
            end
            ST_MUL: begin
                if (kill_i) begin
                    state_n = ST_IDLE;
                end else if (count_q == LAST_ITER) begin
                    state_n = ST_FIN;
                end
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                if (kill_i) begin
                    state_n = ST_IDLE;
                end else if (count_q == LAST_ITER) begin
                    state_n = ST_FIN;
                end
            end
`endif
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
            count_q  <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_mul_q <= 1'b0;
        end else begin
            busy_o <= (state_n != ST_IDLE);
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_mul || start_div) begin
                        count_q  <= '0;
                        p_hi_q   <= '0;
                        is_mul_q <= start_mul;
                        if (start_mul) begin
                            opnd_q   <= rs_mag;
                            p_lo_q   <= rt_mag;
                            neg_lo_q <= rs_neg ^ rt_neg;
                            neg_hi_q <= 1'b0;
                        end else begin
`ifdef MULDIV_DIV_EN
                            // Zero divisor: leaving the quotient unsigned yields all-ones,
                            // and the remainder fix restores the original dividend.
                            opnd_q   <= rt_mag;
                            p_lo_q   <= rs_mag;
                            neg_lo_q <= (rs_neg ^ rt_neg) & ~rt_zero;
                            neg_hi_q <= rs_neg;
`endif
                        end
                    end else if (start_ok && (op_i == OP_MTHI)) begin
                        hi_o <= rs_i;
                    end else if (start_ok && (op_i == OP_MTLO)) begin
                        lo_o <= rs_i;
                    end
                end
                ST_MUL: begin
                    count_q <= count_q + CNT_W'(1);
                    p_hi_q  <= mul_sum[DATA_W:1];
                    p_lo_q  <= {mul_sum[0], p_lo_q[DATA_W-1:1]};
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    count_q <= count_q + CNT_W'(1);
                    p_hi_q  <= div_ge ? DATA_W'(div_shift - {1'b0, opnd_q}) : div_shift[DATA_W-1:0];
                    p_lo_q  <= {p_lo_q[DATA_W-2:0], div_ge};
                end
`endif
                ST_FIN: begin
                    if (!kill_i) begin
                        hi_o   <= fix_hi;
                        lo_o   <= fix_lo;
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: 64-bit arithmetic reference model, queue of expected HI/LO.
module tb_hilo_muldiv;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        start_i = 1'b0;
    logic        kill_i  = 1'b0;
    logic [2:0]  op_i    = 3'b000;
    logic [31:0] rs_i    = '0;
    logic [31:0] rt_i    = '0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    hilo_muldiv dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .kill_i  (kill_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            OP_MULT: begin
                sq = sa * sb;
                return sq;
            end
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic bit op_active(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (DIV_EN && ((op == OP_DIV) || (op == OP_DIVU)));
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from IDLE and check busy/done timing relative to the sampling edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int busy_n, done_n, done_at;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        if (op_active(op)) exp_q.push_back(ref_result(op, a, b));
        @(posedge clk_i);
        #1 start_i = 1'b0;
        if (op == OP_MTHI) mdl_hi = a;
        if (op == OP_MTLO) mdl_lo = a;
        if (op_active(op)) begin
            busy_n  = 0;
            done_n  = 0;
            done_at = 0;
            for (int i = 1; i <= 36; i++) begin
                @(negedge clk_i);
                if (busy_o) busy_n++;
                if (done_o) begin
                    done_n++;
                    if (done_at == 0) done_at = i;
                end
            end
            chk("busy_cycles", 64'(busy_n), 64'd33);
            chk("done_cycle", 64'(done_at), 64'd34);
            chk("done_width", 64'(done_n), 64'd1);
        end else begin
            @(negedge clk_i);
            chk("busy_idle_op", 64'(busy_o), 64'd0);
        end
    endtask

    // Monitor: pop on done, otherwise HI/LO must hold the model value.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                if (done_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(done_o), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hilo_result", {hi_o, lo_o}, e);
                        mdl_hi = e[63:32];
                        mdl_lo = e[31:0];
                    end
                end else begin
                    chk("hilo_hold", {hi_o, lo_o}, {mdl_hi, mdl_lo});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        #1 rst_i = 1'b0;
        #2;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7);
        run_op(OP_DIVU,  32'd100,       32'd7);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIVU,  32'd10,        32'd0);
        run_op(OP_MTLO,  32'h0000_0055, 32'd0);
        run_op(3'b110,   32'hAAAA_AAAA, 32'd3);

        // Ignored restart at k+5, kill at k+10.
        run_op(OP_MTHI, 32'h0000_1234, 32'd0);
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_MULT; rs_i = 32'd5; rt_i = 32'd6;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_MULTU; rs_i = 32'd7; rt_i = 32'd9;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        chk("busy_after_ignored_start", 64'(busy_o), 64'd1);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1 kill_i = 1'b0;
        chk("busy_after_kill", 64'(busy_o), 64'd0);
        repeat (40) @(negedge clk_i);
        chk("hi_after_kill", 64'(hi_o), 64'h1234);

        // Kill in IDLE suppresses a simultaneous start, including MTLO.
        @(negedge clk_i);
        start_i = 1'b1; kill_i = 1'b1; op_i = OP_MULTU; rs_i = 32'd3; rt_i = 32'd3;
        @(posedge clk_i);
        #1 start_i = 1'b0; kill_i = 1'b0;
        chk("busy_kill_start", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        start_i = 1'b1; kill_i = 1'b1; op_i = OP_MTLO; rs_i = 32'hDEAD_BEEF;
        @(posedge clk_i);
        #1 start_i = 1'b0; kill_i = 1'b0;
        repeat (40) @(negedge clk_i);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_MULTU; rs_i = 32'hFFFF_0001; rt_i = 32'h0000_FFFF;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2 rst_i = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        exp_q.delete();
        #1;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;
        run_op(OP_MULTU, 32'd3, 32'd4);
        chk("multu_3x4_lo", 64'(lo_o), 64'd12);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_val();
            rb  = pick_val();
            run_op(rop, ra, rb);
        end

        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
